// File: rtl/muldiv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_share_arbiter
// Purpose  : Shares one iterative unsigned multiply/divide engine among
//            NUM_REQ lanes. Lanes are granted round-robin. The engine then
//            runs a shift-add multiply or a restoring divide, one bit per
//            cycle, and returns the result with a one-cycle done pulse for
//            the owning lane.
// Ports    : clk    - core clock
//            reset  - synchronous, active-high reset
//            req    - per-lane request, held until that lane's done
//            op     - per-lane operation (0 = MUL, 1 = DIV)
//            rs, rt - flattened operands, lane i at [i*DATA_BITS +: DATA_BITS]
//            grant  - one-hot engine owner while BUSY
//            busy   - engine occupied
//            done   - one-hot, one-cycle completion pulse
//            result - registered result, held until the next completion
// Options  : MULDIV_ZERO_SHORTCUT_EN - when defined, an operation with a zero
//            operand completes on the capture edge without entering BUSY.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             op,
    input  logic [NUM_REQ*DATA_BITS-1:0]   rs,
    input  logic [NUM_REQ*DATA_BITS-1:0]   rt,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [NUM_REQ-1:0]             done,
    output logic [DATA_BITS-1:0]           result
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state,  w_state_nxt;
    logic [NUM_REQ-1:0]     r_grant,  w_grant_nxt;
    logic [NUM_REQ-1:0]     r_done,   w_done_nxt;
    logic [DATA_BITS-1:0]   r_result, w_result_nxt;
    logic [c_PTR_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [c_PTR_W-1:0]     r_owner,  w_owner_nxt;
    logic [c_CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic                   r_op,     w_op_nxt;
    logic [DATA_BITS-1:0]   r_a,      w_a_nxt;    // multiplicand / dividend (shifted for DIV)
    logic [DATA_BITS-1:0]   r_b,      w_b_nxt;    // multiplier / divisor
    logic [DATA_BITS-1:0]   r_acc,    w_acc_nxt;  // product / quotient
    logic [DATA_BITS-1:0]   r_rem,    w_rem_nxt;  // partial remainder

    // Per-lane operand views
    logic [DATA_BITS-1:0]   w_rs_arr [NUM_REQ];
    logic [DATA_BITS-1:0]   w_rt_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_rs_arr[g] = rs[g*DATA_BITS +: DATA_BITS];
        assign w_rt_arr[g] = rt[g*DATA_BITS +: DATA_BITS];
    end

    // Round-robin winner search
    logic [NUM_REQ-1:0]     w_elig;
    logic                   w_found;
    logic [c_PTR_W-1:0]     w_win;
    logic [c_PTR_W:0]       w_idx;
    logic [NUM_REQ-1:0]     w_win_oh;
    logic [DATA_BITS-1:0]   w_sel_rs;
    logic [DATA_BITS-1:0]   w_sel_rt;
    logic                   w_sel_op;
    logic                   w_shortcut;

    // A lane pulsing done this cycle is excluded so it cannot be re-granted
    // on the same edge.
    assign w_elig = req & ~r_done;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(i);
            if (w_idx >= (c_PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (c_PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && w_elig[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_win_oh = NUM_REQ'(1) << w_win;
    assign w_sel_rs = w_rs_arr[w_win];
    assign w_sel_rt = w_rt_arr[w_win];
    assign w_sel_op = op[w_win];

`ifdef MULDIV_ZERO_SHORTCUT_EN
    assign w_shortcut = (w_sel_rs == '0) || (w_sel_rt == '0);
`else
    assign w_shortcut = 1'b0;
`endif

    function automatic logic [c_PTR_W-1:0] inc_mod(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(NUM_REQ-1)) ? '0 : p + 1'b1;
    endfunction

    // One iteration of the datapath
    logic [DATA_BITS-1:0]   w_partial;
    logic [DATA_BITS:0]     w_rem_sh;
    logic [DATA_BITS:0]     w_diff;
    logic                   w_fits;
    logic [DATA_BITS-1:0]   w_acc_iter;
    logic [DATA_BITS-1:0]   w_rem_iter;

    assign w_partial  = r_b[r_cnt] ? (r_a << r_cnt) : '0;
    // Restoring divide: bring the next dividend bit (MSB first) into the remainder.
    assign w_rem_sh   = {r_rem, r_a[DATA_BITS-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    // A zero divisor always "fits", which naturally yields an all-ones quotient.
    assign w_fits     = (w_rem_sh >= {1'b0, r_b});
    assign w_acc_iter = r_op ? {r_acc[DATA_BITS-2:0], w_fits} : (r_acc + w_partial);
    assign w_rem_iter = w_fits ? w_diff[DATA_BITS-1:0] : w_rem_sh[DATA_BITS-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_result_nxt = r_result;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_rem;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (w_shortcut) begin
                        w_result_nxt = (w_sel_op && (w_sel_rt == '0)) ? '1 : '0;
                        w_done_nxt   = w_win_oh;
                        w_rr_ptr_nxt = inc_mod(w_win);
                    end else begin
                        w_op_nxt    = w_sel_op;
                        w_a_nxt     = w_sel_rs;
                        w_b_nxt     = w_sel_rt;
                        w_acc_nxt   = '0;
                        w_rem_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_grant_nxt = w_win_oh;
                        w_owner_nxt = w_win;
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_acc_nxt = w_acc_iter;
                w_rem_nxt = w_rem_iter;
                w_a_nxt   = r_op ? (r_a << 1) : r_a;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_CNT_W'(DATA_BITS-1)) begin
                    w_result_nxt = w_acc_iter;
                    w_done_nxt   = r_grant;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = inc_mod(r_owner);
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_rem    <= w_rem_nxt;
        end
    end

    assign grant  = r_grant;
    assign busy   = (r_state == S_BUSY);
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_share_arbiter
// Purpose  : Self-checking bench for muldiv_share_arbiter (4 lanes, 8 bits).
//            Expected results come from plain arithmetic, expected grant
//            order from a round-robin pointer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done;
    logic [7:0]  result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_ptr  = 0;

    muldiv_share_arbiter #(.NUM_REQ(4), .DATA_BITS(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .grant  (grant),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // One active edge, then land on the falling edge to sample and drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_res(input logic opv, input logic [7:0] a, input logic [7:0] b);
        if (!opv)         return 8'((int'(a) * int'(b)) % 256);
        else if (b == 0)  return 8'hFF;
        else              return 8'(int'(a) / int'(b));
    endfunction

    function automatic bit is_shortcut(input logic [7:0] a, input logic [7:0] b);
`ifdef MULDIV_ZERO_SHORTCUT_EN
        return (a == 0) || (b == 0);
`else
        return 1'b0 && (a == b);
`endif
    endfunction

    task automatic set_lane(input int lane, input logic opv, input logic [7:0] a, input logic [7:0] b);
        op[lane]       = opv;
        rs[lane*8 +: 8] = a;
        rt[lane*8 +: 8] = b;
    endtask

    // Single-lane operation: checks latency, grant, result and done pulse.
    task automatic do_op(input string tag, input int lane, input logic opv,
                         input logic [7:0] a, input logic [7:0] b);
        int  n;
        bit  seen_grant;
        bit  sc;
        n          = 0;
        seen_grant = 0;
        sc         = is_shortcut(a, b);
        set_lane(lane, opv, a, b);
        req[lane] = 1'b1;
        while (done == 4'b0 && n < 30) begin
            tick();
            n++;
            if (grant != 4'b0 && !seen_grant) begin
                seen_grant = 1;
                chk({tag, "_grant"}, 32'(grant), 32'(1 << lane));
            end
        end
        chk({tag, "_latency"}, 32'(n), sc ? 32'd1 : 32'd9);
        chk({tag, "_done"}, 32'(done), 32'(1 << lane));
        chk({tag, "_result"}, 32'(result), 32'(ref_res(opv, a, b)));
        chk({tag, "_grant_seen"}, 32'(seen_grant), 32'(!sc));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        req[lane] = 1'b0;
        tick();
        chk({tag, "_done_clear"}, 32'(done), 32'd0);
        exp_ptr = (lane + 1) % 4;
    endtask

    initial begin
        logic [7:0] fa [4];
        logic [7:0] fb [4];
        logic       fo [4];
        logic [7:0] ma, mb;
        logic       mo;
        int         lane, n, last, g;
        bit         flag;

        reset = 1'b1;
        req   = '0;
        op    = '0;
        rs    = '0;
        rt    = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);

        // Single MUL on lane 0 with cycle-exact timing
        set_lane(0, 1'b0, 8'd12, 8'd11);
        req[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mul0_grant_Ek", 32'(grant), 32'b0001);
            chk("mul0_done_Ek", 32'(done), 32'd0);
        end
        tick();
        chk("mul0_done_E8", 32'(done), 32'b0001);
        chk("mul0_result_E8", 32'(result), 32'd132);
        chk("mul0_grant_E8", 32'(grant), 32'd0);
        req[0] = 1'b0;
        tick();
        chk("mul0_done_clear", 32'(done), 32'd0);
        chk("mul0_busy_after", 32'(busy), 32'd0);
        exp_ptr = 1;

        do_op("div2", 2, 1'b1, 8'd200, 8'd7);
        do_op("mul1", 1, 1'b0, 8'd20, 8'd20);
        do_op("div0", 3, 1'b1, 8'd55, 8'd0);

        // Randomized single-lane operations, zero operands included
        for (int r = 0; r < 16; r++) begin
            lane = int'($urandom_range(0, 3));
            mo   = 1'($urandom_range(0, 1));
            ma   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            mb   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            do_op("rand", lane, mo, ma, mb);
        end

        // Round-robin fairness with all lanes requesting continuously
        for (int i = 0; i < 4; i++) begin
            fo[i] = 1'($urandom_range(0, 1));
            fa[i] = 8'($urandom_range(1, 255));
            fb[i] = 8'($urandom_range(1, 255));
            set_lane(i, fo[i], fa[i], fb[i]);
        end
        req  = 4'hF;
        lane = exp_ptr;
        last = 0;
        for (g = 0; g < 5; g++) begin
            n = 0;
            while (grant == 4'b0 && n < 20) begin tick(); n++; end
            chk("rr_grant", 32'(grant), 32'(1 << lane));
            if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd9);
            last = cyc;
            n = 0;
            while (done == 4'b0 && n < 20) begin tick(); n++; end
            chk("rr_done", 32'(done), 32'(1 << lane));
            chk("rr_result", 32'(result), 32'(ref_res(fo[lane], fa[lane], fb[lane])));
            chk("rr_no_grant_at_done", 32'(grant), 32'd0);
            if (g == 4) req = 4'b0;
            lane = (lane + 1) % 4;
        end
        exp_ptr = lane;
        tick();
        chk("rr_idle_done", 32'(done), 32'd0);
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Lane 1 drops req at E3 and scrambles operands at E4
        mo = 1'($urandom_range(0, 1));
        ma = 8'($urandom_range(1, 255));
        mb = 8'($urandom_range(1, 255));
        set_lane(1, mo, ma, mb);
        req[1] = 1'b1;
        tick(); tick(); tick();           // E0..E2
        req[1] = 1'b0;
        tick();                           // E3
        set_lane(1, ~mo, ~ma, 8'd0);
        for (int k = 0; k < 5; k++) tick(); // E4..E8
        chk("midop_done", 32'(done), 32'b0010);
        chk("midop_result", 32'(result), 32'(ref_res(mo, ma, mb)));
        tick();
        chk("midop_done_clear", 32'(done), 32'd0);
        chk("midop_busy", 32'(busy), 32'd0);

        // Reset asserted at E5 of a MUL on lane 2
        set_lane(2, 1'b0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        req[2] = 1'b1;
        for (int k = 0; k < 5; k++) tick(); // E0..E4
        reset = 1'b1;
        tick();                             // E5 with reset
        reset  = 1'b0;
        req[2] = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        flag = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done != 4'b0) flag = 1;
        end
        chk("rst_no_late_done", 32'(flag), 32'd0);

        set_lane(0, 1'b1, 8'd99, 8'd9);
        set_lane(2, 1'b0, 8'd3, 8'd5);
        req = 4'b0101;
        tick();
        chk("rst_lane0_first", 32'(grant), 32'b0001);
        n = 0;
        while (done == 4'b0 && n < 20) begin tick(); n++; end
        chk("rst_lane0_done", 32'(done), 32'b0001);
        chk("rst_lane0_result", 32'(result), 32'd11);
        req = 4'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_share_arbiter.md
Name: muldiv_share_arbiter

Overview:
- Shares one iterative 8-bit multiply/divide engine among NUM_REQ per-thread ALUs, so each lane does not need its own MUL/DIV array.
- Lanes raise a request with operands. The block arbitrates round-robin and runs a shift-add multiply or restoring divide, one bit per cycle.
- It returns the result with a one-cycle per-lane done pulse.
- It sits between the core's per-thread ALUs and a single shared MUL/DIV datapath, inside each compute core.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- DATA_BITS, 8, operand/result width; also the iteration count.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-lane request; held high until that lane's done.
- op  input  NUM_REQ  per-lane operation: 0 = MUL, 1 = DIV.
- rs  input  NUM_REQ*DATA_BITS  flattened first operands; lane i at [i*DATA_BITS +: DATA_BITS].
- rt  input  NUM_REQ*DATA_BITS  flattened second operands, same packing.
- grant  output  NUM_REQ  one-hot owner of the engine; high during BUSY only.
- busy  output  1  engine occupied (state != IDLE).
- done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- result  output  DATA_BITS  registered result; valid in the cycle done is high, held until the next completion.

Behaviour:
- Single clock; reset is synchronous, active-high.
- Reset values: state=IDLE, grant=0, busy=0, done=0, result=0, rr_ptr=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation: no done pulse, and the lane must re-request.
- States are IDLE and BUSY.

IDLE:
- Eligible lanes = req & ~done. A lane whose done is high this cycle cannot be re-granted on the same edge.
- Winner = first eligible lane scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- On an edge with any eligible lane:
  - capture the winner's op, rs and rt;
  - set grant to the one-hot winner and the counter to 0;
  - move to BUSY.
- With no eligible lane, stay in IDLE.

BUSY:
- One iteration per edge, counter 0..DATA_BITS-1.
- MUL: shift-add. If multiplier bit[k] is set, add (multiplicand << k). Keep the low DATA_BITS bits only (modulo 2^DATA_BITS).
- DIV: restoring division, MSB first. Quotient is unsigned and the remainder is discarded.
- rt==0 yields an all-ones quotient (8'hFF at the default width).
- On the edge completing iteration DATA_BITS-1:
  - result <= final value;
  - done <= grant;
  - grant <= 0;
  - rr_ptr <= (winner+1) mod NUM_REQ;
  - state <= IDLE.
- done is cleared on the following edge, so it pulses for exactly one cycle.

Timing and handshake rules:
- Latency: request captured at edge E0, done high in the cycle after edge E8 (at DATA_BITS=8). A new grant is possible at E9.
- Throughput: one operation per DATA_BITS+1 cycles.
- Changes to req, op, rs or rt during BUSY are ignored.
- A lane dropping req mid-operation still receives its done pulse.
- Operands are unsigned throughout.

Optional Feature:
- Macro: MULDIV_ZERO_SHORTCUT_EN.
- Defined: at the capture edge, if the captured rs==0 or rt==0, BUSY is skipped.
  - At E0: result <= (MUL: 0; DIV with rt==0: all-ones; DIV with rs==0, rt!=0: 0), done <= winner one-hot, rr_ptr advances, state stays IDLE.
  - grant never asserts for that operation.
- Undefined: every operation takes the full DATA_BITS iterations; results are identical.

Test Plan:
- Reset then single MUL: lane0 req, op=0, rs=12, rt=11.
  - grant=0001 at E0..E7; at E8 result=132, done=0001 for one cycle; busy=0 afterwards.
- DIV and overflow: lane2 DIV rs=200, rt=7 -> result=28. lane1 MUL rs=20, rt=20 -> result=144 (400 mod 256).
- Divide by zero: lane3 DIV rs=55, rt=0 -> result=8'hFF.
  - Without the macro: done at E8.
  - With MULDIV_ZERO_SHORTCUT_EN: done at E0, grant never high.
- Round-robin fairness: all four lanes hold req continuously.
  - Grant order is 0,1,2,3,0; each new grant arrives 9 cycles after the previous one.
  - A lane is never re-granted in its own done cycle.
- Mid-operation events:
  - lane1 drops req at E3 -> done[1] still pulses at E8.
  - Operands changed at E4 -> result still uses the values captured at E0.
- Reset mid-operation: assert reset at E5 of a MUL.
  - Next cycle: busy=0, grant=0, done=0, result=0, and no done pulse later.
  - After reset, lane0 wins first (rr_ptr=0).
